ahb2apb: RTL and testbench

Simplified AHB-to-APB bridge with four built-in APB slaves, each holding four 32-bit registers. The bridge samples an AHB-style address and a write/read control bit, then runs a three-state APB sequence (IDLE → SETUP → ENABLE) to write HWDATA into, or read HRDATA from, the addressed slave register. It is a self-contained peripheral-register island: there is no external APB port, and all APB signalling is internal.

---
 rtl/ahb2apb_pkg.sv | 29 ++
 rtl/apb_slave.sv | 36 +++
 rtl/ahb2apb.sv | 105 ++++++++++
 tb/tb_ahb2apb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: shared types and constants for the AHB-to-APB register island.
//   state_e     : bridge FSM states (IDLE -> SETUP -> ENABLE)
//   field consts: HADDR bit positions of the slave select and register index
//   slv_onehot  : slave number -> one-hot PSEL vector
package ahb2apb_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 4;
  localparam int NUM_REG = 4;

  localparam int SLV_MSB = 9;
  localparam int SLV_LSB = 8;
  localparam int REG_MSB = 3;
  localparam int REG_LSB = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2
  } state_e;

  function automatic logic [NUM_SLV-1:0] slv_onehot(input logic [1:0] slv);
    logic [NUM_SLV-1:0] sel;
    sel      = '0;
    sel[slv] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/apb_slave.sv
// apb_slave: APB target holding a bank of four 32-bit registers.
//   PCLK, PRESETn : clock, asynchronous active-low clear of the bank
//   PSEL, PENABLE, PWRITE, PADDR[1:0], PWDATA : APB request
//   PRDATA        : combinational read of the addressed register
module apb_slave
  import ahb2apb_pkg::*;
(
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [1:0]        PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA
);

  logic [DATA_W-1:0] regs_q [NUM_REG];

  // Registers commit only in the access phase of a selected write.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REG; gi++) begin : g_reg
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          regs_q[gi] <= '0;
        end else if (PSEL && PENABLE && PWRITE && (PADDR == 2'(gi))) begin
          regs_q[gi] <= PWDATA;
        end
      end
    end
  endgenerate

  assign PRDATA = regs_q[PADDR];

endmodule

// File: rtl/ahb2apb.sv
// ahb2apb: simplified AHB-to-APB bridge with four internal APB slaves.
//   HCLK    : clock (rising edge)
//   HRST    : asynchronous active-low reset
//   HADDR   : address, [9:8] slave, [3:2] register, other bits ignored
//   Control : 1 = write, 0 = read, sampled with HADDR
//   HWDATA  : write data, sampled one cycle after the address
//   HRDATA  : registered read data, updated only at the end of a read
// The FSM free-runs IDLE -> SETUP -> ENABLE; a stable request simply repeats.
module ahb2apb
  import ahb2apb_pkg::*;
(
  input  logic              HCLK,
  input  logic              HRST,
  input  logic [31:0]       HADDR,
  input  logic              Control,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA
);

  state_e            state_q, state_d;
  logic [1:0]        slv_q, slv_d;
  logic [1:0]        reg_q, reg_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;

  logic [3:0]         paddr;
  logic [NUM_SLV-1:0] psel;
  logic               penable;
  logic [DATA_W-1:0]  prdata;
  logic [DATA_W-1:0]  prdata_s [NUM_SLV];

  // Address bits outside the decoded fields alias by design.
  logic unused_haddr;
  assign unused_haddr = ^{HADDR[31:10], HADDR[7:4], HADDR[1:0]};

  always_ff @(posedge HCLK or negedge HRST) begin
    if (!HRST) begin
      state_q  <= IDLE;
      slv_q    <= '0;
      reg_q    <= '0;
      write_q  <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      slv_q    <= slv_d;
      reg_q    <= reg_d;
      write_q  <= write_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slv_d    = slv_q;
    reg_d    = reg_q;
    write_d  = write_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    penable  = 1'b0;
    case (state_q)
      IDLE: begin
        slv_d   = HADDR[SLV_MSB:SLV_LSB];
        reg_d   = HADDR[REG_MSB:REG_LSB];
        write_d = Control;
        state_d = SETUP;
      end
      SETUP: begin
        // HWDATA arrives one cycle after its address, i.e. now.
        if (write_q) pwdata_d = HWDATA;
        state_d = ENABLE;
      end
      ENABLE: begin
        penable = 1'b1;
        if (!write_q) hrdata_d = prdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign paddr  = {slv_q, reg_q};
  assign psel   = (state_q == IDLE) ? '0 : slv_onehot(paddr[3:2]);
  assign prdata = prdata_s[paddr[3:2]];
  assign HRDATA = hrdata_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      apb_slave u_slv (
        .PCLK    (HCLK),
        .PRESETn (HRST),
        .PSEL    (psel[gi]),
        .PENABLE (penable),
        .PWRITE  (write_q),
        .PADDR   (paddr[1:0]),
        .PWDATA  (pwdata_q),
        .PRDATA  (prdata_s[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ahb2apb.sv
module tb_ahb2apb;

  logic        HCLK;
  logic        HRST;
  logic [31:0] HADDR;
  logic        Control;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;

  int checks = 0;
  int errors = 0;

  ahb2apb dut (
    .HCLK    (HCLK),
    .HRST    (HRST),
    .HADDR   (HADDR),
    .Control (Control),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // One 3-cycle access. Entered just after an edge that left the FSM in IDLE,
  // returns just after the ENABLE edge. hr_mid is HRDATA during ENABLE.
  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                        output logic [31:0] hr_mid, output logic [31:0] hr_end);
    HADDR   = addr;
    Control = wr;
    @(posedge HCLK); #1;
    HWDATA  = data;
    @(posedge HCLK); #1;
    hr_mid  = HRDATA;
    @(posedge HCLK); #1;
    hr_end  = HRDATA;
    $display("%s addr=%08h wdata=%08h hrdata=%08h", wr ? "WR" : "RD", addr, data, hr_end);
  endtask

  task automatic test_reset();
    logic [31:0] m, e;
    HRST = 1'b0; HADDR = '0; Control = 1'b0; HWDATA = '0;
    #3;
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_hrdata: got %08h expected %08h", HRDATA, 32'h0);
    end
    repeat (3) @(posedge HCLK);
    #1 HRST = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 4; r++) begin
        access(32'((s << 8) | (r << 2)), 1'b0, 32'h0, m, e);
        checks++;
        if (e !== 32'h0) begin
          errors++;
          $display("FAIL reset_reg s%0d r%0d: got %08h expected %08h", s, r, e, 32'h0);
        end
      end
    end
  endtask

  task automatic test_write_sweep();
    logic [31:0] addrs [4] = '{32'h00C, 32'h10C, 32'h20C, 32'h30C};
    logic [31:0] datas [4] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    logic [31:0] m, e;
    for (int i = 0; i < 4; i++) begin
      access(addrs[i], 1'b1, datas[i], m, e);
      checks++;
      if (e !== 32'h0) begin
        errors++;
        $display("FAIL write_hold_hrdata %0d: got %08h expected %08h", i, e, 32'h0);
      end
    end
  endtask

  task automatic test_read_sweep();
    logic [31:0] addrs [4] = '{32'h00C, 32'h10C, 32'h20C, 32'h30C};
    logic [31:0] datas [4] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    logic [31:0] m, e;
    for (int i = 0; i < 4; i++) begin
      access(addrs[i], 1'b0, 32'h0, m, e);
      if (i > 0) begin
        checks++;
        if (m !== datas[i-1]) begin
          errors++;
          $display("FAIL read_hold %0d: got %08h expected %08h", i, m, datas[i-1]);
        end
      end
      checks++;
      if (e !== datas[i]) begin
        errors++;
        $display("FAIL read_sweep %08h: got %08h expected %08h", addrs[i], e, datas[i]);
      end
    end
  endtask

  task automatic test_isolation();
    logic [31:0] addrs [5] = '{32'h104, 32'h100, 32'h108, 32'h10C, 32'h004};
    logic [31:0] exps  [5] = '{32'h12345678, 32'h0, 32'h0, 32'hBBBBBBBB, 32'h0};
    logic [31:0] m, e;
    access(32'h104, 1'b1, 32'h12345678, m, e);
    checks++;
    if (e !== 32'hDDDDDDDD) begin
      errors++;
      $display("FAIL iso_write_hold: got %08h expected %08h", e, 32'hDDDDDDDD);
    end
    // First read is back-to-back with the write to the same register.
    for (int i = 0; i < 5; i++) begin
      access(addrs[i], 1'b0, 32'h0, m, e);
      checks++;
      if (e !== exps[i]) begin
        errors++;
        $display("FAIL isolation %08h: got %08h expected %08h", addrs[i], e, exps[i]);
      end
    end
  endtask

  task automatic test_aliasing();
    logic [31:0] m, e;
    access(32'hFFFFF2F8, 1'b1, 32'h5A5A5A5A, m, e);
    access(32'h00000208, 1'b0, 32'h0, m, e);
    checks++;
    if (e !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL alias_208: got %08h expected %08h", e, 32'h5A5A5A5A);
    end
    access(32'h0000020C, 1'b0, 32'h0, m, e);
    checks++;
    if (e !== 32'hCCCCCCCC) begin
      errors++;
      $display("FAIL alias_20C: got %08h expected %08h", e, 32'hCCCCCCCC);
    end
    access(32'h00000208, 1'b0, 32'h0, m, e);
  endtask

  task automatic test_mid_reset();
    logic [31:0] m, e;
    HADDR   = 32'h000;
    Control = 1'b1;
    @(posedge HCLK); #1;
    HWDATA  = 32'h11111111;
    HRST    = 1'b0;          // FSM is in SETUP of the write
    #1;
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL midrst_hrdata_async: got %08h expected %08h", HRDATA, 32'h0);
    end
    Control = 1'b0;
    HWDATA  = 32'h0;
    repeat (2) @(posedge HCLK);
    #1 HRST = 1'b1;
    access(32'h000, 1'b0, 32'h0, m, e);
    checks++;
    if (e !== 32'h0) begin
      errors++;
      $display("FAIL midrst_reg000: got %08h expected %08h", e, 32'h0);
    end
    access(32'h104, 1'b0, 32'h0, m, e);
    checks++;
    if (e !== 32'h0) begin
      errors++;
      $display("FAIL midrst_reg104: got %08h expected %08h", e, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_write_sweep();
    test_read_sweep();
    test_isolation();
    test_aliasing();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
